// File: rtl/alu_top.sv
// Registered N-bit unsigned ALU with 16 operations and a 2N-bit result.
// Combinational datapath into one output register, so results have one cycle of latency.
module alu_top #(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   operand1,
   input  logic [N-1:0]   operand2,
   input  logic [N-1:0]   select,
   output logic [2*N-1:0] result
);

   localparam int unsigned W = 2 * N;

   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] b_div;
   logic [W-1:0] result_c;
   logic         sel_unused_c;

   assign a = W'(operand1);
   assign b = W'(operand2);

   // Divisor forced nonzero so the divider never sees zero; the zero case is selected separately
   assign b_div = (b == '0) ? W'(1) : b;

   // Only the low four select bits are decoded
   assign sel_unused_c = ^select;

   always_comb begin
      result_c = '0;
      case (select[3:0])
         4'd0:    result_c = a + b;
         4'd1:    result_c = a - b;
         4'd2:    result_c = a * b;
         4'd3:    result_c = (b == '0) ? a : (a % b_div);
         4'd4:    result_c = (b == '0) ? '1 : (a / b_div);
         4'd5:    result_c = a & b;
         4'd6:    result_c = a | b;
         4'd7:    result_c = a ^ b;
         4'd8:    result_c = W'((a != '0) && (b != '0));
         4'd9:    result_c = W'((a != '0) || (b != '0));
         4'd10:   result_c = a << 1;
         4'd11:   result_c = a >> 1;
         4'd12:   result_c = W'(a == b);
         4'd13:   result_c = W'(a != b);
         4'd14:   result_c = W'(a < b);
         4'd15:   result_c = W'(a > b);
         default: result_c = '0;
      endcase
   end

   // Output register; reset clears it immediately and discards any pending value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result <= '0;
      end else begin
         result <= result_c;
      end
   end

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: driver pushes expected results, monitor pops and compares.
// Directed cases, mid-stream reset, back-to-back sweep and randomized operations.
module tb_alu_top;

   localparam int unsigned N = 4;
   localparam int unsigned W = 2 * N;
   localparam int unsigned NDIR = 24;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] operand1;
   logic [N-1:0] operand2;
   logic [N-1:0] select;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int           sel_q[$];
   logic         mon_rst;

   int dir_a[NDIR]   = '{2, 9, 5, 12, 15, 7, 12, 7, 7, 9, 5, 1, 9, 0, 5, 0, 4, 15, 4, 5, 3, 9, 13, 7};
   int dir_b[NDIR]   = '{1, 5, 9, 10, 15, 4, 6, 0, 0, 8, 10, 3, 8, 8, 10, 0, 0, 0, 0, 5, 8, 7, 10, 7};
   int dir_s[NDIR]   = '{0, 1, 1, 2, 2, 3, 4, 4, 3, 5, 6, 7, 8, 8, 9, 9, 10, 10, 11, 12, 13, 14, 15, 15};
   int dir_e[NDIR]   = '{3, 4, 252, 120, 225, 3, 2, 255, 7, 8, 15, 2, 1, 0, 1, 0, 8, 30, 2, 1, 1, 0, 1, 0};

   alu_top #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .operand1 (operand1),
      .operand2 (operand2),
      .select   (select),
      .result   (result)
   );

   always #5 clk = ~clk;

   // Reference model computed with plain integer arithmetic
   function automatic logic [W-1:0] model(longint a, longint b, int sel);
      longint m;
      longint r;
      m = longint'(1) << W;
      case (sel)
         0:  r = a + b;
         1:  r = (a - b + m) % m;
         2:  r = a * b;
         3:  r = (b == 0) ? a : a % b;
         4:  r = (b == 0) ? m - 1 : a / b;
         5:  r = a & b;
         6:  r = a | b;
         7:  r = a ^ b;
         8:  r = (a != 0 && b != 0) ? 1 : 0;
         9:  r = (a != 0 || b != 0) ? 1 : 0;
         10: r = a * 2;
         11: r = a / 2;
         12: r = (a == b) ? 1 : 0;
         13: r = (a != b) ? 1 : 0;
         14: r = (a < b) ? 1 : 0;
         15: r = (a > b) ? 1 : 0;
         default: r = 0;
      endcase
      return W'(r);
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drive one operation after the falling edge; also releases reset
   task automatic drive(input int a, input int b, input int sel, input logic [W-1:0] exp, input bit push);
      @(negedge clk);
      operand1 = N'(a);
      operand2 = N'(b);
      select   = N'(sel);
      reset    = 1'b1;
      if (push) begin
         exp_q.push_back(exp);
         sel_q.push_back(sel);
      end
   endtask

   // Monitor: every edge that captures (reset high) must match the oldest expectation
   initial begin
      forever begin
         @(posedge clk);
         mon_rst = reset;
         #1;
         if (mon_rst === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_capture got %0h expected none", result);
            end else begin
               int s;
               logic [W-1:0] e;
               e = exp_q.pop_front();
               s = sel_q.pop_front();
               check($sformatf("sel%0d", s), result, e);
            end
         end
      end
   end

   initial begin
      int a;
      int b;
      int s;
      reset    = 1'b0;
      operand1 = '0;
      operand2 = '0;
      select   = '0;

      // Reset held with clock running; drive live inputs to show they are ignored
      repeat (2) @(negedge clk);
      operand1 = N'(7);
      operand2 = N'(3);
      select   = N'(2);
      @(negedge clk);
      check("reset_hold", result, '0);
      @(negedge clk);
      check("reset_hold2", result, '0);

      for (int i = 0; i < NDIR; i++) begin
         drive(dir_a[i], dir_b[i], dir_s[i], W'(dir_e[i]), 1'b1);
      end

      // Mid-stream reset between edges discards the pending operation
      drive(3, 4, 2, W'(12), 1'b1);
      drive(6, 3, 0, '0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("midreset_async", result, '0);
      @(posedge clk);
      #1;
      check("midreset_hold", result, '0);
      drive(9, 2, 4, W'(4), 1'b1);

      // Back-to-back sweep of every select code
      for (int i = 0; i < 16; i++) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         drive(a, b, i, model(longint'(a), longint'(b), i), 1'b1);
      end

      for (int i = 0; i < 150; i++) begin
         a = int'($urandom_range(0, 15));
         b = (i % 8 == 0) ? 0 : int'($urandom_range(0, 15));
         s = int'($urandom_range(0, 15));
         drive(a, b, s, model(longint'(a), longint'(b), s), 1'b1);
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
